// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU among NREQ requesters
module alu_arbiter #(
   parameter int NREQ = 2,
   parameter int W    = 64,
   parameter int CW   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_A,
   input  logic [NREQ*W-1:0] req_B,
   input  logic [NREQ*3-1:0] req_cntrl,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [W-1:0]      rsp_result,
   output logic [3:0]        rsp_flags,
   output logic [W-1:0]      alu_A,
   output logic [W-1:0]      alu_B,
   output logic [2:0]        alu_cntrl,
   input  logic [W-1:0]      alu_result,
   input  logic              alu_negative,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   input  logic              alu_carry_out,
   output logic              busy,
   output logic [CW-1:0]     op_count
);

   localparam int PW = (NREQ > 2) ? 2 : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] owner;
   logic [PW-1:0] grant;
   logic          grant_found;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [2:0]    op_cntrl;
   logic [W-1:0]  sel_a;
   logic [W-1:0]  sel_b;
   logic [2:0]    sel_cntrl;
   logic          rsp_accept;

   // Lowest valid index overall, then overridden by the lowest valid index at or above rr_ptr.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant       = PW'(i);
            grant_found = 1'b1;
         end
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (PW'(i) >= rr_ptr)) begin
            grant = PW'(i);
         end
      end
   end

   always_comb begin
      sel_a     = '0;
      sel_b     = '0;
      sel_cntrl = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == PW'(i)) begin
            sel_a     = req_A[i*W +: W];
            sel_b     = req_B[i*W +: W];
            sel_cntrl = req_cntrl[i*3 +: 3];
         end
      end
   end

   assign req_ready  = ((state == IDLE) && grant_found) ? (NREQ'(1) << grant) : '0;
   assign rsp_accept = (state == RESP) && (|(rsp_valid & rsp_ready));
   assign busy       = (state != IDLE);
   assign alu_A      = op_a;
   assign alu_B      = op_b;
   assign alu_cntrl  = op_cntrl;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         op_a       <= '0;
         op_b       <= '0;
         op_cntrl   <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_valid  <= '0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  op_a     <= sel_a;
                  op_b     <= sel_b;
                  op_cntrl <= sel_cntrl;
                  owner    <= grant;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_flags  <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
               rsp_valid  <= NREQ'(1) << owner;
               state      <= RESP;
            end
            RESP: begin
               // Only the owner's rsp_ready bit can complete the op.
               if (rsp_accept) begin
                  rsp_valid <= '0;
                  rr_ptr    <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
                  op_count  <= op_count + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and arbitration model
module tb_alu_arbiter;

   localparam int NREQ = 2;
   localparam int W    = 64;
   localparam int CW   = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_A;
   logic [NREQ*W-1:0] req_B;
   logic [NREQ*3-1:0] req_cntrl;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [W-1:0]      rsp_result;
   logic [3:0]        rsp_flags;
   logic [W-1:0]      alu_A;
   logic [W-1:0]      alu_B;
   logic [2:0]        alu_cntrl;
   logic [W-1:0]      alu_result;
   logic              alu_negative;
   logic              alu_zero;
   logic              alu_overflow;
   logic              alu_carry_out;
   logic              busy;
   logic [CW-1:0]     op_count;

   int pass_cnt    = 0;
   int total_cnt   = 0;
   int model_rr    = 0;
   int model_count = 0;

   logic [W-1:0] qa [NREQ];
   logic [W-1:0] qb [NREQ];
   logic [2:0]   qc [NREQ];

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_A(req_A), .req_B(req_B), .req_cntrl(req_cntrl),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl),
      .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
      .busy(busy), .op_count(op_count)
   );

   // Returns {negative, zero, overflow, carry_out, result}.
   function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         cy;
      logic         ov;
      cy = 1'b0;
      ov = 1'b0;
      s  = '0;
      case (c)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[W-1:0];
            cy = s[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'b011: begin
            s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            r  = s[W-1:0];
            cy = s[W];
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'b100: r = a ^ b;
         3'b101: r = ~(a | b);
         3'b110: r = a << b[5:0];
         default: r = a >> b[5:0];
      endcase
      return {r[W-1], (r == '0), ov, cy, r};
   endfunction

   always_comb begin
      {alu_negative, alu_zero, alu_overflow, alu_carry_out, alu_result} = alu_fn(alu_A, alu_B, alu_cntrl);
   end

   function automatic int model_grant(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         int i = (model_rr + k) % NREQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
      qa[i] = a;
      qb[i] = b;
      qc[i] = c;
      req_A[i*W +: W]     = a;
      req_B[i*W +: W]     = b;
      req_cntrl[i*3 +: 3] = c;
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      @(negedge clk);
      reset       = 1'b0;
      model_rr    = 0;
      model_count = 0;
   endtask

   task automatic test_reset;
      reset     = 1'b1;
      req_valid = '1;
      rsp_ready = '1;
      set_req(0, 64'd5, 64'd3, 3'b010);
      set_req(1, 64'd9, 64'd4, 3'b011);
      repeat (2) @(negedge clk);
      reset     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (req_ready !== '0) $display("FAIL reset_req_ready got %b exp 00", req_ready); else pass_cnt++;
      total_cnt++; if (rsp_valid !== '0) $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_result !== '0) $display("FAIL reset_rsp_result got %h exp 0", rsp_result); else pass_cnt++;
      total_cnt++; if (rsp_flags !== 4'b0) $display("FAIL reset_rsp_flags got %b exp 0000", rsp_flags); else pass_cnt++;
      total_cnt++; if (op_count !== '0) $display("FAIL reset_op_count got %0d exp 0", op_count); else pass_cnt++;
      total_cnt++; if ({alu_A, alu_B, alu_cntrl} !== '0) $display("FAIL reset_op_regs got %h %h %b exp 0", alu_A, alu_B, alu_cntrl); else pass_cnt++;
      @(negedge clk); #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_hold got %b exp 0", busy); else pass_cnt++;
   endtask

   task automatic test_directed;
      int           ti [4] = '{0, 1, 1, 0};
      logic [W-1:0] ta [4] = '{64'd5, 64'd3, 64'd7, 64'h7FFF_FFFF_FFFF_FFFF};
      logic [W-1:0] tb [4] = '{64'd3, 64'd5, 64'd7, 64'd1};
      logic [2:0]   tc [4] = '{3'b010, 3'b011, 3'b011, 3'b010};
      logic [W-1:0] tr [4] = '{64'd8, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'h8000_0000_0000_0000};
      logic [3:0]   tf [4] = '{4'b0000, 4'b1000, 4'b0101, 4'b1010};
      logic [NREQ-1:0] oh;
      do_reset;
      for (int k = 0; k < 4; k++) begin
         oh = NREQ'(1) << ti[k];
         set_req(ti[k], ta[k], tb[k], tc[k]);
         req_valid = oh;
         #1;
         total_cnt++; if (req_ready !== oh) $display("FAIL dir_ready[%0d] got %b exp %b", k, req_ready, oh); else pass_cnt++;
         @(negedge clk);
         req_valid = '0;
         #1;
         total_cnt++; if ({busy, rsp_valid} !== {1'b1, NREQ'(0)}) $display("FAIL dir_exec[%0d] got busy %b rsp_valid %b exp 1 00", k, busy, rsp_valid); else pass_cnt++;
         total_cnt++; if ({alu_A, alu_B, alu_cntrl} !== {ta[k], tb[k], tc[k]}) $display("FAIL dir_alu_in[%0d] got %h %h %b exp %h %h %b", k, alu_A, alu_B, alu_cntrl, ta[k], tb[k], tc[k]); else pass_cnt++;
         @(negedge clk); #1;
         total_cnt++; if (rsp_valid !== oh) $display("FAIL dir_rsp_valid[%0d] got %b exp %b", k, rsp_valid, oh); else pass_cnt++;
         total_cnt++; if (rsp_result !== tr[k]) $display("FAIL dir_result[%0d] got %h exp %h", k, rsp_result, tr[k]); else pass_cnt++;
         total_cnt++; if (rsp_flags !== tf[k]) $display("FAIL dir_flags[%0d] got %b exp %b", k, rsp_flags, tf[k]); else pass_cnt++;
         rsp_ready = oh;
         @(negedge clk);
         rsp_ready = '0;
         #1;
         total_cnt++; if (op_count !== CW'(k + 1)) $display("FAIL dir_op_count[%0d] got %0d exp %0d", k, op_count, k + 1); else pass_cnt++;
      end
   endtask

   task automatic test_round_robin;
      int              g;
      int              order [$];
      logic [W+3:0]    exp;
      logic [NREQ-1:0] oh;
      do_reset;
      req_valid = '1;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NREQ; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
         g   = model_grant(req_valid);
         oh  = NREQ'(1) << g;
         exp = alu_fn(qa[g], qb[g], qc[g]);
         order.push_back(g);
         #1;
         total_cnt++; if (req_ready !== oh) $display("FAIL rr_grant[%0d] got %b exp %b", k, req_ready, oh); else pass_cnt++;
         @(negedge clk); #1;
         total_cnt++; if (req_ready !== '0) $display("FAIL rr_exec_ready[%0d] got %b exp 00", k, req_ready); else pass_cnt++;
         @(negedge clk); #1;
         total_cnt++; if (rsp_valid !== oh) $display("FAIL rr_rsp_valid[%0d] got %b exp %b", k, rsp_valid, oh); else pass_cnt++;
         total_cnt++; if ({rsp_flags, rsp_result} !== exp) $display("FAIL rr_result[%0d] got %b %h exp %b %h", k, rsp_flags, rsp_result, exp[W+3:W], exp[W-1:0]); else pass_cnt++;
         rsp_ready = '1;
         @(negedge clk);
         rsp_ready   = '0;
         model_rr    = (g + 1) % NREQ;
         model_count = model_count + 1;
      end
      req_valid = '0;
      #1;
      total_cnt++; if (order != '{0, 1, 0, 1, 0, 1}) $display("FAIL rr_order got %p exp 0,1,0,1,0,1", order); else pass_cnt++;
      total_cnt++; if (op_count !== CW'(6)) $display("FAIL rr_op_count got %0d exp 6", op_count); else pass_cnt++;
   endtask

   task automatic test_backpressure;
      logic [W+3:0] exp0;
      logic [W+3:0] exp1;
      do_reset;
      set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 3'b010);
      exp0      = alu_fn(qa[0], qb[0], qc[0]);
      req_valid = 2'b01;
      #1;
      total_cnt++; if (req_ready !== 2'b01) $display("FAIL bp_grant0 got %b exp 01", req_ready); else pass_cnt++;
      @(negedge clk);
      set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 3'b011);
      exp1      = alu_fn(qa[1], qb[1], qc[1]);
      req_valid = 2'b11;
      @(negedge clk);
      rsp_ready = 2'b10;
      for (int j = 0; j < 5; j++) begin
         #1;
         total_cnt++; if (rsp_valid !== 2'b01) $display("FAIL bp_rsp_valid[%0d] got %b exp 01", j, rsp_valid); else pass_cnt++;
         total_cnt++; if (rsp_result !== exp0[W-1:0]) $display("FAIL bp_result[%0d] got %h exp %h", j, rsp_result, exp0[W-1:0]); else pass_cnt++;
         total_cnt++; if (req_ready !== 2'b00) $display("FAIL bp_req_ready[%0d] got %b exp 00", j, req_ready); else pass_cnt++;
         @(negedge clk);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = '0;
      #1;
      total_cnt++; if (req_ready !== 2'b10) $display("FAIL bp_grant1 got %b exp 10", req_ready); else pass_cnt++;
      total_cnt++; if (op_count !== CW'(1)) $display("FAIL bp_op_count got %0d exp 1", op_count); else pass_cnt++;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk); #1;
      total_cnt++; if (rsp_valid !== 2'b10) $display("FAIL bp_rsp_valid1 got %b exp 10", rsp_valid); else pass_cnt++;
      total_cnt++; if ({rsp_flags, rsp_result} !== exp1) $display("FAIL bp_result1 got %b %h exp %b %h", rsp_flags, rsp_result, exp1[W+3:W], exp1[W-1:0]); else pass_cnt++;
      rsp_ready = 2'b10;
      @(negedge clk);
      rsp_ready = '0;
   endtask

   task automatic test_reset_mid_exec;
      do_reset;
      set_req(0, 64'd1, 64'd2, 3'b010);
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = '0;
      set_req(1, 64'd4, 64'd6, 3'b010);
      req_valid = 2'b10;
      #1;
      total_cnt++; if (req_ready !== 2'b10) $display("FAIL mid_grant1 got %b exp 10", req_ready); else pass_cnt++;
      @(negedge clk);
      reset     = 1'b1;
      req_valid = '0;
      @(negedge clk);
      reset     = 1'b0;
      #1;
      total_cnt++; if ({busy, rsp_valid} !== 3'b000) $display("FAIL mid_idle got busy %b rsp_valid %b exp 0 00", busy, rsp_valid); else pass_cnt++;
      total_cnt++; if (op_count !== '0) $display("FAIL mid_op_count got %0d exp 0", op_count); else pass_cnt++;
      req_valid = 2'b11;
      #1;
      total_cnt++; if (req_ready !== 2'b01) $display("FAIL mid_priority got %b exp 01", req_ready); else pass_cnt++;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk); #1;
      total_cnt++; if (rsp_valid !== 2'b01) $display("FAIL mid_rsp_owner got %b exp 01", rsp_valid); else pass_cnt++;
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = '0;
   endtask

   task automatic test_random;
      int              g;
      int              stall;
      logic [W+3:0]    exp;
      logic [NREQ-1:0] oh;
      do_reset;
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) set_req(i, qa[i], qa[i], qc[i]);
         end
         req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         g   = model_grant(req_valid);
         oh  = NREQ'(1) << g;
         exp = alu_fn(qa[g], qb[g], qc[g]);
         #1;
         total_cnt++; if (req_ready !== oh) $display("FAIL rnd_grant[%0d] got %b exp %b", k, req_ready, oh); else pass_cnt++;
         @(negedge clk);
         req_valid = NREQ'($urandom);
         #1;
         total_cnt++; if ({busy, rsp_valid, req_ready} !== {1'b1, NREQ'(0), NREQ'(0)}) $display("FAIL rnd_exec[%0d] got %b %b %b exp 1 00 00", k, busy, rsp_valid, req_ready); else pass_cnt++;
         @(negedge clk);
         stall = $urandom_range(0, 3);
         for (int j = 0; j < stall; j++) begin
            rsp_ready = NREQ'($urandom) & ~oh;
            #1;
            total_cnt++; if ({rsp_valid, rsp_flags, rsp_result} !== {oh, exp}) $display("FAIL rnd_stall[%0d] got %b %b %h exp %b %b %h", k, rsp_valid, rsp_flags, rsp_result, oh, exp[W+3:W], exp[W-1:0]); else pass_cnt++;
            @(negedge clk);
         end
         rsp_ready = NREQ'($urandom) | oh;
         #1;
         total_cnt++; if ({rsp_valid, rsp_flags, rsp_result} !== {oh, exp}) $display("FAIL rnd_rsp[%0d] got %b %b %h exp %b %b %h", k, rsp_valid, rsp_flags, rsp_result, oh, exp[W+3:W], exp[W-1:0]); else pass_cnt++;
         @(negedge clk);
         rsp_ready   = '0;
         model_rr    = (g + 1) % NREQ;
         model_count = model_count + 1;
         #1;
         total_cnt++; if (op_count !== CW'(model_count)) $display("FAIL rnd_op_count[%0d] got %0d exp %0d", k, op_count, model_count); else pass_cnt++;
      end
      req_valid = '0;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_A     = '0;
      req_B     = '0;
      req_cntrl = '0;
      test_reset;
      test_directed;
      test_round_robin;
      test_backpressure;
      test_reset_mid_exec;
      test_random;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t with %0d/%0d checks passed", $time, pass_cnt, total_cnt);
      $fatal(1);
   end

endmodule
